data_mem_lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/data_mem_lsu_load_formatter.sv | 28 ++
 rtl/data_mem_lsu.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MaxWaitDefault = 15;
  localparam int unsigned WaitCntW       = 4;

  // Byte-lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_enables(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic funct3_illegal(input logic [2:0] funct3, input logic is_store);
    logic bad;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_lsu_load_formatter.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_formatter
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        off_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = word_i[{off_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    result_o = {{(DATA_W - 8){byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{(DATA_W - 16){half_sel[15]}}, half_sel};
      F3_BU:   result_o = {{(DATA_W - 8){1'b0}}, byte_sel};
      F3_HU:   result_o = {{(DATA_W - 16){1'b0}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core MEM stage and a word-organised data SRAM with a
// variable-latency ready handshake; stalls the core while an access is in flight.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              fault,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e          state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                is_load_q, is_load_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic                timeout_q, timeout_d;

  logic                req;
  logic                bad_access;
  logic [DATA_W-1:0]   wdata_repl;
  logic [DATA_W-1:0]   load_fmt;

  localparam logic [WaitCntW-1:0] CntLast = WaitCntW'(MAX_WAIT - 1);

  // Formatting uses the captured size/offset so the core may change addr while stalled.
  load_formatter #(
    .DATA_W(DATA_W)
  ) u_load_formatter (
    .funct3_i(f3_q),
    .off_i   (off_q),
    .word_i  (mem_rdata),
    .result_o(load_fmt)
  );

  assign req        = mem_read | mem_write;
  assign bad_access = funct3_illegal(funct3, mem_write) | misaligned(funct3, addr[1:0]);

  always_comb begin
    case (funct3)
      F3_B, F3_BU: wdata_repl = {(DATA_W / 8){wr_data[7:0]}};
      F3_H, F3_HU: wdata_repl = {(DATA_W / 16){wr_data[15:0]}};
      default:     wdata_repl = wr_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    is_load_d   = is_load_q;
    f3_d        = f3_q;
    off_d       = off_q;
    timeout_d   = timeout_q;
    stall       = 1'b0;
    fault       = 1'b0;
    bus_err     = 1'b0;

    case (state_q)
      StIdle: begin
        if (req) begin
          if (bad_access) begin
            fault = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = StBusy;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            // Store wins when both request lines are raised.
            mem_we_d    = mem_write;
            is_load_d   = ~mem_write;
            mem_addr_d  = addr[ADDR_W-1:2];
            mem_be_d    = lane_enables(funct3, addr[1:0]);
            mem_wdata_d = wdata_repl;
            f3_d        = funct3;
            off_d       = addr[1:0];
            timeout_d   = 1'b0;
          end
        end
      end

      StBusy: begin
        stall = 1'b1;
        if (mem_ready) begin
          if (is_load_q) begin
            rd_data_d = load_fmt;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == CntLast) begin
          if (is_load_q) begin
            rd_data_d = '0;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + WaitCntW'(1);
        end
      end

      StDone: begin
        bus_err   = timeout_q;
        timeout_d = 1'b0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      is_load_q   <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      is_load_q   <= is_load_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu with hand-computed expectations.
module tb_data_mem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [8:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        stall, fault, bus_err;
  logic        mem_req, mem_we;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        acc_stall, acc_fault;
    logic        req, we;
    logic [6:0]  maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stall_cycles, req_cycles;
    logic        done_seen, done_stall, done_err;
    logic [31:0] done_rd;
    logic        post_req, post_stall, post_fault, post_err;
    logic [31:0] post_rd;
  } obs_t;

  data_mem_lsu dut (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .funct3   (funct3),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .stall    (stall),
    .fault    (fault),
    .bus_err  (bus_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Drives one core request starting in IDLE; ready pulses in BUSY cycle 'lat' (-1: never).
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3, input logic [8:0] a,
                      input logic [31:0] wd, input logic [31:0] rdat, input int lat,
                      output obs_t o);
    o = '{default: '0};
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wr_data = wd;
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    o.acc_stall = stall; o.acc_fault = fault; o.stall_cycles = int'(stall);
    @(posedge clk); #1;
    o.req = mem_req; o.we = mem_we; o.maddr = mem_addr; o.be = mem_be; o.wdata = mem_wdata;
    if (!o.acc_stall) begin
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      o.post_fault = fault; o.post_req = mem_req; o.post_stall = stall; o.post_rd = rd_data;
      return;
    end
    for (int i = 0; i < 40 && !o.done_seen; i++) begin
      if (i == lat) begin mem_ready = 1'b1; mem_rdata = rdat; end
      #1;
      o.stall_cycles += int'(stall); o.req_cycles += int'(mem_req);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (!stall) begin
        o.done_seen = 1'b1; o.done_stall = stall; o.done_err = bus_err; o.done_rd = rd_data;
        o.post_req = mem_req;
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        o.post_err = bus_err; o.post_stall = stall; o.post_rd = rd_data;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wr_data = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, rd_data} !== '0) begin
      fails++;
      $display("FAIL reset_regs: req=%b we=%b addr=%h be=%b wdata=%h rd=%h required all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, rd_data);
    end
    tests++;
    if ({stall, fault, bus_err} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: stall/fault/bus_err=%b required 000",
                        {stall, fault, bus_err});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    obs_t o;
    xact(1, 0, F3_W, 9'h010, 32'h0, 32'hDEADBEEF, 0, o);
    tests++; if (!o.done_seen) begin fails++; $display("FAIL lw_done: no DONE seen"); end
    tests++; if (o.maddr !== 7'h04) begin fails++; $display("FAIL lw_addr: got %h required 04", o.maddr); end
    tests++; if (o.be !== 4'b1111 || o.we !== 1'b0 || o.req !== 1'b1) begin
      fails++; $display("FAIL lw_req: be=%b we=%b req=%b required 1111 0 1", o.be, o.we, o.req);
    end
    tests++; if (o.stall_cycles != 2) begin
      fails++; $display("FAIL lw_stall: got %0d cycles required 2", o.stall_cycles);
    end
    tests++; if (o.done_rd !== 32'hDEADBEEF || o.post_req !== 1'b0) begin
      fails++; $display("FAIL lw_data: rd=%h req=%b required DEADBEEF 0", o.done_rd, o.post_req);
    end
  endtask

  task automatic test_load_sizes();
    obs_t o;
    xact(1, 0, F3_B, 9'h013, 32'h0, 32'h80112233, 0, o);
    tests++; if (o.be !== 4'b1000 || o.done_rd !== 32'hFFFFFF80) begin
      fails++; $display("FAIL lb: be=%b rd=%h required 1000 FFFFFF80", o.be, o.done_rd);
    end
    xact(1, 0, F3_BU, 9'h013, 32'h0, 32'h80112233, 0, o);
    tests++; if (o.done_rd !== 32'h00000080) begin
      fails++; $display("FAIL lbu: rd=%h required 00000080", o.done_rd);
    end
    xact(1, 0, F3_H, 9'h012, 32'h0, 32'h80112233, 0, o);
    tests++; if (o.be !== 4'b1100 || o.done_rd !== 32'hFFFF8011) begin
      fails++; $display("FAIL lh: be=%b rd=%h required 1100 FFFF8011", o.be, o.done_rd);
    end
    xact(1, 0, F3_HU, 9'h01E, 32'h0, 32'hBEEF0000, 3, o);
    tests++; if (o.done_rd !== 32'h0000BEEF || o.maddr !== 7'h07) begin
      fails++; $display("FAIL lhu: rd=%h addr=%h required 0000BEEF 07", o.done_rd, o.maddr);
    end
    tests++; if (o.stall_cycles != 5) begin
      fails++; $display("FAIL lhu_stall: got %0d cycles required 5", o.stall_cycles);
    end
  endtask

  task automatic test_store();
    obs_t o;
    xact(0, 1, F3_B, 9'h005, 32'h000000A5, 32'h0, 0, o);
    tests++; if (o.we !== 1'b1 || o.be !== 4'b0010 || o.wdata !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL sb: we=%b be=%b wdata=%h required 1 0010 A5A5A5A5", o.we, o.be, o.wdata);
    end
    tests++; if (o.maddr !== 7'h01 || o.done_rd !== 32'h0000BEEF) begin
      fails++; $display("FAIL sb_addr_rd: addr=%h rd=%h required 01 0000BEEF", o.maddr, o.done_rd);
    end
    xact(0, 1, F3_H, 9'h006, 32'h00001234, 32'h0, 1, o);
    tests++; if (o.be !== 4'b1100 || o.wdata !== 32'h12341234) begin
      fails++; $display("FAIL sh: be=%b wdata=%h required 1100 12341234", o.be, o.wdata);
    end
    xact(1, 1, F3_W, 9'h008, 32'hCAFEF00D, 32'h55555555, 0, o);
    tests++; if (o.we !== 1'b1 || o.wdata !== 32'hCAFEF00D || o.maddr !== 7'h02) begin
      fails++; $display("FAIL sw_both: we=%b wdata=%h addr=%h required 1 CAFEF00D 02",
                        o.we, o.wdata, o.maddr);
    end
    tests++; if (o.done_rd !== 32'h0000BEEF) begin
      fails++; $display("FAIL sw_both_rd: rd=%h required 0000BEEF", o.done_rd);
    end
  endtask

  task automatic test_faults();
    obs_t o;
    logic [2:0] f3s [4] = '{F3_W, F3_H, 3'b011, F3_BU};
    logic [8:0] as  [4] = '{9'h011, 9'h003, 9'h000, 9'h004};
    logic       wrs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      xact(~wrs[k], wrs[k], f3s[k], as[k], 32'hFFFFFFFF, 32'h0, 0, o);
      tests++;
      if (o.acc_fault !== 1'b1 || o.acc_stall !== 1'b0 || o.req !== 1'b0 || o.post_fault !== 1'b0
          || o.post_req !== 1'b0 || o.post_rd !== 32'h0000BEEF) begin
        fails++;
        $display("FAIL fault_%0d: fault=%b stall=%b req=%b fault_next=%b req_next=%b rd=%h required 1 0 0 0 0 0000BEEF",
                 k, o.acc_fault, o.acc_stall, o.req, o.post_fault, o.post_req, o.post_rd);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    xact(1, 0, F3_W, 9'h020, 32'h0, 32'h0, -1, o);
    tests++; if (!o.done_seen) begin fails++; $display("FAIL to_done: no DONE seen"); end
    tests++; if (o.req_cycles != 15 || o.post_req !== 1'b0) begin
      fails++; $display("FAIL to_req: req cycles=%0d req_after=%b required 15 0", o.req_cycles, o.post_req);
    end
    tests++; if (o.done_err !== 1'b1 || o.done_stall !== 1'b0 || o.done_rd !== 32'h0) begin
      fails++; $display("FAIL to_done_out: bus_err=%b stall=%b rd=%h required 1 0 00000000",
                        o.done_err, o.done_stall, o.done_rd);
    end
    tests++; if (o.post_err !== 1'b0 || o.stall_cycles != 16) begin
      fails++; $display("FAIL to_pulse: bus_err_next=%b stall cycles=%0d required 0 16",
                        o.post_err, o.stall_cycles);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    mem_read = 1; mem_write = 0; funct3 = F3_W; addr = 9'h040; mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_read = 0; mem_ready = 1; mem_rdata = 32'h11111111;
    #1;
    tests++; if ({mem_req, stall, mem_be} !== 6'b0 || rd_data !== 32'h0) begin
      fails++; $display("FAIL rst_mid: req=%b stall=%b be=%b rd=%h required 0 0 0000 00000000",
                        mem_req, stall, mem_be, rd_data);
    end
    @(posedge clk); #1;
    mem_ready = 0;
    tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || rd_data !== 32'h0) begin
      fails++; $display("FAIL rst_late_ready: req=%b stall=%b rd=%h required 0 0 00000000",
                        mem_req, stall, rd_data);
    end
    xact(1, 0, F3_W, 9'h044, 32'h0, 32'h0BADCAFE, 0, o);
    tests++; if (o.maddr !== 7'h11 || o.done_rd !== 32'h0BADCAFE || o.stall_cycles != 2) begin
      fails++; $display("FAIL rst_next_lw: addr=%h rd=%h stall=%0d required 11 0BADCAFE 2",
                        o.maddr, o.done_rd, o.stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_sizes();
    test_store();
    test_faults();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
